sram_audio_ctrl: RTL

Sequencer for the 256Kx16 audio SRAM port. It decides when the SRAM is read and when it is written, and drives the read/write strobes, address and write data into the SRAM interface block. Record mode stores ADC samples at consecutive addresses. Play mode streams them back to the DAC, either once or looped, and pause/stop are supported.

---
 rtl/sram_audio_ctrl_if.sv | 33 +++
 rtl/sram_audio_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sram_audio_ctrl_if.sv
// SRAM port bundle between the audio sequencer and the SRAM interface block.
//   addr  : word address, held stable for a whole access
//   read  : read strobe (held for the access duration)
//   write : write strobe (held for the access duration)
//   wdata : data to be written
//   rdata : data returned by the SRAM interface block
// master = sequencer side, slave = SRAM interface block side.
interface sram_audio_ctrl_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output addr,
    output read,
    output write,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  read,
    input  write,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/sram_audio_ctrl.sv
// Record/playback sequencer for the audio SRAM.
// Decides when the SRAM is read or written and holds each strobe for
// ACC_CYC cycles. Record stores ADC samples at consecutive addresses;
// play streams them back to the DAC once or looped; pause/stop supported.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   cmd_record/play/pause/stop : one-cycle command pulses
//   loop                   : playback wraps to address 0 at end of recording
//   adc_valid, adc_data    : sample strobe and data to record
//   dac_req                : DAC asks for the next sample
//   dac_data, dac_valid    : sample read back and its one-cycle strobe
//   sram                   : SRAM bus (addr/read/write/wdata/rdata)
//   state                  : 0=IDLE 1=RECORD 2=PLAY 3=PAUSE
//   rec_len                : number of samples recorded
//   overrun                : strobe dropped because an access was in flight
module sram_audio_ctrl #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int ACC_CYC = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_record,
  input  logic                cmd_play,
  input  logic                cmd_pause,
  input  logic                cmd_stop,
  input  logic                loop,
  input  logic                adc_valid,
  input  logic [DATA_W-1:0]   adc_data,
  input  logic                dac_req,
  output logic [DATA_W-1:0]   dac_data,
  output logic                dac_valid,
  sram_audio_ctrl_if.master   sram,
  output logic [1:0]          state,
  output logic [ADDR_W:0]     rec_len,
  output logic                overrun
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2,
    ST_PAUSE  = 2'd3
  } state_t;

  localparam int CNT_W = (ACC_CYC < 1) ? 1 : $clog2(ACC_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((ACC_CYC < 1) ? 1 : ACC_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]  LEN_ONE  = (ADDR_W+1)'(1);

  // pending command bit positions
  localparam int P_REC   = 0;
  localparam int P_PLAY  = 1;
  localparam int P_PAUSE = 2;
  localparam int P_STOP  = 3;

  state_t            state_reg, state_next;
  state_t            resume_reg, resume_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W:0]   len_reg, len_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              is_read_reg, is_read_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] dac_data_reg, dac_data_next;
  logic              dac_valid_reg, dac_valid_next;
  logic              overrun_reg, overrun_next;
  logic [3:0]        pend_reg, pend_next;

  logic [3:0] pend;
  logic       in_flight;
  logic       strobe;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      resume_reg    <= ST_RECORD;
      addr_reg      <= '0;
      len_reg       <= '0;
      cnt_reg       <= '0;
      is_read_reg   <= 1'b0;
      wdata_reg     <= '0;
      dac_data_reg  <= '0;
      dac_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      pend_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      resume_reg    <= resume_next;
      addr_reg      <= addr_next;
      len_reg       <= len_next;
      cnt_reg       <= cnt_next;
      is_read_reg   <= is_read_next;
      wdata_reg     <= wdata_next;
      dac_data_reg  <= dac_data_next;
      dac_valid_reg <= dac_valid_next;
      overrun_reg   <= overrun_next;
      pend_reg      <= pend_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    resume_next    = resume_reg;
    addr_next      = addr_reg;
    len_next       = len_reg;
    cnt_next       = cnt_reg;
    is_read_next   = is_read_reg;
    wdata_next     = wdata_reg;
    dac_data_next  = dac_data_reg;
    dac_valid_next = 1'b0;
    overrun_next   = 1'b0;

    // current-cycle commands join the sticky ones so an idle engine acts at once
    pend      = pend_reg | {cmd_stop, cmd_pause, cmd_play, cmd_record};
    pend_next = pend;
    in_flight = (cnt_reg != '0);
    strobe    = ((state_reg == ST_RECORD) && adc_valid) ||
                ((state_reg == ST_PLAY)   && dac_req);

    if (in_flight) begin
      if (strobe) overrun_next = 1'b1;
      cnt_next = cnt_reg - CNT_ONE;
      if (cnt_reg == CNT_ONE) begin
        // last strobe cycle: finish the access
        if (is_read_reg) begin
          dac_data_next  = sram.rdata;
          dac_valid_next = 1'b1;
          if ({1'b0, addr_reg} == len_reg - LEN_ONE) begin
            addr_next = '0;
            if (!loop) state_next = ST_IDLE;
          end else begin
            addr_next = addr_reg + 1'b1;
          end
        end else begin
          // addr wraps to 0 naturally after the top word
          addr_next = addr_reg + 1'b1;
          len_next  = {1'b0, addr_reg} + LEN_ONE;
          if (addr_reg == '1) state_next = ST_IDLE;
        end
      end
    end else if (strobe) begin
      cnt_next     = CNT_LOAD;
      is_read_next = (state_reg == ST_PLAY);
      if (state_reg == ST_RECORD) wdata_next = adc_data;
    end else begin
      // engine quiet: commands take effect and are consumed
      pend_next = '0;
      case (state_reg)
        ST_IDLE: begin
          if (pend[P_STOP]) begin
            state_next = ST_IDLE;
          end else if (pend[P_PLAY]) begin
            if (len_reg != '0) begin
              state_next = ST_PLAY;
              addr_next  = '0;
            end
          end else if (pend[P_REC]) begin
            state_next = ST_RECORD;
            addr_next  = '0;
            len_next   = '0;
          end
        end
        ST_RECORD, ST_PLAY: begin
          if (pend[P_STOP]) begin
            state_next = ST_IDLE;
          end else if (pend[P_PAUSE]) begin
            resume_next = state_reg;
            state_next  = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (pend[P_STOP]) begin
            state_next = ST_IDLE;
          end else if (pend[P_PAUSE] || pend[P_PLAY]) begin
            state_next = resume_reg;
          end else if (pend[P_REC]) begin
            state_next = ST_RECORD;
            addr_next  = '0;
            len_next   = '0;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign sram.addr  = addr_reg;
  assign sram.read  = (cnt_reg != '0) &&  is_read_reg;
  assign sram.write = (cnt_reg != '0) && !is_read_reg;
  assign sram.wdata = wdata_reg;

  assign dac_data  = dac_data_reg;
  assign dac_valid = dac_valid_reg;
  assign state     = state_reg;
  assign rec_len   = len_reg;
  assign overrun   = overrun_reg;

endmodule
